// File: rtl/div_iter_unit_if.sv
// div_iter_unit_if: handshake and data bundle between the execute stage and
// the iterative divider.
//   master (execute side): drives start_i, signed_i, dividend_i, divisor_i,
//                          cancel_i; observes result_o, ready_o, busy_o
//   slave  (divider side): the mirror image
//   result_o is {remainder (HI), quotient (LO)}.
interface div_iter_unit_if #(
  parameter int DIV_W = 32
);
  logic               start_i;
  logic               signed_i;
  logic [DIV_W-1:0]   dividend_i;
  logic [DIV_W-1:0]   divisor_i;
  logic               cancel_i;
  logic [2*DIV_W-1:0] result_o;
  logic               ready_o;
  logic               busy_o;

  modport master (
    output start_i, signed_i, dividend_i, divisor_i, cancel_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  start_i, signed_i, dividend_i, divisor_i, cancel_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/div_iter_unit.sv
// div_iter_unit: iterative radix-2 restoring divider for DIV / DIVU.
//   clk  : clock, rising edge
//   rst  : asynchronous, active-low reset
//   bus  : div_iter_unit_if.slave
//          start_i    level request, sampled only in IDLE
//          signed_i   1 = DIV (two's complement), 0 = DIVU
//          dividend_i / divisor_i  operands, captured on accept only
//          cancel_i   flush; forces IDLE, suppresses ready_o
//          result_o   {remainder, quotient}, registered, held until next op
//          ready_o    one-cycle result-valid pulse
//          busy_o     high while iterating
// The unit works on operand magnitudes and applies the sign fix-up in DONE;
// result_o/ready_o are registered out of DONE, so the pulse appears in the
// cycle after DONE.
module div_iter_unit #(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  div_iter_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int               CNT_W    = $clog2(DIV_W + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_W - 1);
  localparam logic [DIV_W-1:0] ZERO_W   = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] ONE_W    = DIV_W'(1);
  localparam logic [DIV_W-1:0] ONES_W   = {DIV_W{1'b1}};

  // Two's complement negation when en is set.
  function automatic logic [DIV_W-1:0] neg_if(input logic [DIV_W-1:0] v,
                                              input logic             en);
    if (en) begin
      neg_if = (~v) + ONE_W;
    end else begin
      neg_if = v;
    end
  endfunction

  // Magnitude of an operand; the most negative value maps onto itself,
  // which is its correct unsigned magnitude.
  function automatic logic [DIV_W-1:0] mag(input logic [DIV_W-1:0] v,
                                           input logic             is_signed);
    mag = neg_if(v, is_signed & v[DIV_W-1]);
  endfunction

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIV_W-1:0]     rem_q, rem_d;     // partial remainder
  logic [DIV_W-1:0]     quo_q, quo_d;     // dividend shifting out, quotient in
  logic [DIV_W:0]       dvsr_q, dvsr_d;   // divisor magnitude
  logic                 qneg_q, qneg_d;   // negate quotient at fix-up
  logic                 rneg_q, rneg_d;   // negate remainder at fix-up
  logic [2*DIV_W-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;

  logic [DIV_W:0]       rem_sh_s;
  logic                 fits_s;

  // One restoring step: shift in the next dividend bit, trial-subtract.
  always_comb begin
    rem_sh_s = {rem_q, quo_q[DIV_W-1]};
    fits_s   = (rem_sh_s >= dvsr_q);
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    ready_d  = 1'b0;

    if (bus.cancel_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start_i) begin
            cnt_d  = CNT_ZERO;
            dvsr_d = {1'b0, mag(bus.divisor_i, bus.signed_i)};
            if (bus.divisor_i == ZERO_W) begin
              // Zero divisor: preload the architected result, no fix-up.
              rem_d   = bus.dividend_i;
              quo_d   = ONES_W;
              qneg_d  = 1'b0;
              rneg_d  = 1'b0;
              state_d = S_DONE;
            end else begin
              rem_d   = ZERO_W;
              quo_d   = mag(bus.dividend_i, bus.signed_i);
              qneg_d  = bus.signed_i &
                        (bus.dividend_i[DIV_W-1] ^ bus.divisor_i[DIV_W-1]);
              rneg_d  = bus.signed_i & bus.dividend_i[DIV_W-1];
              state_d = S_BUSY;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_BUSY: begin
          // Remainder stays below the divisor, so it always fits DIV_W bits.
          rem_d = fits_s ? DIV_W'(rem_sh_s - dvsr_q) : rem_sh_s[DIV_W-1:0];
          quo_d = {quo_q[DIV_W-2:0], fits_s};
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_BUSY;
          end
        end
        S_DONE: begin
          result_d = {neg_if(rem_q, rneg_q), neg_if(quo_q, qneg_q)};
          ready_d  = 1'b1;
          state_d  = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d == S_BUSY);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= CNT_ZERO;
      rem_q    <= ZERO_W;
      quo_q    <= ZERO_W;
      dvsr_q   <= {1'b0, ZERO_W};
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= {ZERO_W, ZERO_W};
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
  assign bus.busy_o   = busy_q;

endmodule

// File: tb/tb_div_iter_unit.sv
// tb_div_iter_unit: directed bench for div_iter_unit with a result scoreboard.
module tb_div_iter_unit;

  localparam int W = 32;

  logic        clk;
  logic        rst;
  int          passed    = 0;
  int          total     = 0;
  int          ready_cnt = 0;
  logic [63:0] sb_q[$];
  logic [63:0] last_res  = 64'd0;

  div_iter_unit_if #(.DIV_W(W)) bus();

  div_iter_unit #(.DIV_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every ready pulse seen at a clock edge.
  always @(posedge clk) begin
    if (bus.ready_o === 1'b1) ready_cnt <= ready_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Called one step after the accept edge; returns in the ready cycle.
  task automatic wait_result(input string tag, input int exp_lat,
                             input int exp_busy);
    int          lat;
    int          busy_cyc;
    logic [63:0] exp;
    lat = 0;
    busy_cyc = 0;
    while ((bus.ready_o !== 1'b1) && (lat < 100)) begin
      if (bus.busy_o === 1'b1) busy_cyc++;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(exp_busy));
    exp = 64'd0;
    if (sb_q.size() > 0) exp = sb_q.pop_front();
    if (bus.ready_o === 1'b1) begin
      chk({tag, "_result"}, bus.result_o, exp);
      chk({tag, "_busy_at_ready"}, 64'(bus.busy_o), 64'd0);
      last_res = exp;
    end
  endtask

  // One complete operation; operands are scrambled right after accept.
  task automatic run_op(input string tag, input logic sg,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int exp_lat,
                        input int exp_busy);
    int rc0;
    rc0 = ready_cnt;
    bus.signed_i   = sg;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    bus.start_i    = 1'b1;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    bus.start_i    = 1'b0;
    bus.dividend_i = ~a;
    bus.divisor_i  = b ^ 32'h0000_00F3;
    bus.signed_i   = ~sg;
    wait_result(tag, exp_lat, exp_busy);
    @(posedge clk); #1;
    chk({tag, "_ready_single"}, 64'(bus.ready_o), 64'd0);
    chk({tag, "_ready_count"}, 64'(ready_cnt - rc0), 64'd1);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] e;
    longint      q;
    longint      r;
    int          rc0;

    rst            = 1'b0;
    bus.start_i    = 1'b0;
    bus.cancel_i   = 1'b0;
    bus.signed_i   = 1'b0;
    bus.dividend_i = 32'd0;
    bus.divisor_i  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_result", bus.result_o, 64'd0);
    chk("reset_ready", 64'(bus.ready_o), 64'd0);
    chk("reset_busy", 64'(bus.busy_o), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed values from the plan.
    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 32);
    run_op("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33, 32);
    run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 32);
    run_op("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 32);
    run_op("divu_by0", 1'b0, 32'h12345678, 32'd0, 64'h12345678_FFFFFFFF, 1, 0);
    run_op("div_by0", 1'b1, 32'hFFFFFFFB, 32'd0, 64'hFFFFFFFB_FFFFFFFF, 1, 0);

    // Random operands against a truncating-division model.
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = (i < 3) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (b == 32'd0) b = 32'd1;
      if (i[0]) begin
        q = longint'($signed(a)) / longint'($signed(b));
        r = longint'($signed(a)) % longint'($signed(b));
      end else begin
        q = longint'(a) / longint'(b);
        r = longint'(a) % longint'(b);
      end
      e = {r[31:0], q[31:0]};
      run_op("rand", i[0], a, b, e, 33, 32);
    end

    // Cancel ten cycles into an operation.
    rc0 = ready_cnt;
    bus.signed_i   = 1'b0;
    bus.dividend_i = 32'd1000;
    bus.divisor_i  = 32'd3;
    bus.start_i    = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    bus.cancel_i = 1'b1;
    @(posedge clk); #1;
    bus.cancel_i = 1'b0;
    chk("cancel_busy", 64'(bus.busy_o), 64'd0);
    chk("cancel_ready", 64'(bus.ready_o), 64'd0);
    repeat (40) begin @(posedge clk); #1; end
    chk("cancel_no_ready", 64'(ready_cnt - rc0), 64'd0);
    chk("cancel_result_held", bus.result_o, last_res);
    run_op("after_cancel_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 32);

    // Start and cancel together in IDLE: no accept.
    rc0 = ready_cnt;
    bus.dividend_i = 32'd5;
    bus.divisor_i  = 32'd1;
    bus.start_i    = 1'b1;
    bus.cancel_i   = 1'b1;
    @(posedge clk); #1;
    chk("start_cancel_busy", 64'(bus.busy_o), 64'd0);
    bus.start_i  = 1'b0;
    bus.cancel_i = 1'b0;
    repeat (40) begin @(posedge clk); #1; end
    chk("start_cancel_no_ready", 64'(ready_cnt - rc0), 64'd0);

    // start_i held across DONE: second op accepted at the end of the ready cycle.
    rc0 = ready_cnt;
    bus.signed_i   = 1'b0;
    bus.dividend_i = 32'd20;
    bus.divisor_i  = 32'd6;
    bus.start_i    = 1'b1;
    sb_q.push_back(64'h00000002_00000003);
    @(posedge clk); #1;
    wait_result("held_first", 33, 32);
    bus.dividend_i = 32'd50;
    bus.divisor_i  = 32'd7;
    sb_q.push_back(64'h00000001_00000007);
    @(posedge clk); #1;
    chk("held_accept_busy", 64'(bus.busy_o), 64'd1);
    chk("held_accept_ready", 64'(bus.ready_o), 64'd0);
    bus.start_i    = 1'b0;
    bus.dividend_i = 32'd0;
    bus.divisor_i  = 32'd0;
    wait_result("held_second", 33, 32);
    @(posedge clk); #1;
    chk("held_ready_count", 64'(ready_cnt - rc0), 64'd2);

    // Asynchronous reset in cycle 15 of BUSY.
    bus.signed_i   = 1'b0;
    bus.dividend_i = 32'hDEADBEEF;
    bus.divisor_i  = 32'd3;
    bus.start_i    = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    chk("rst_busy_before", 64'(bus.busy_o), 64'd1);
    rc0 = ready_cnt;
    rst = 1'b0;
    #1;
    chk("rst_result", bus.result_o, 64'd0);
    chk("rst_ready", 64'(bus.ready_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (40) begin @(posedge clk); #1; end
    chk("rst_no_ready", 64'(ready_cnt - rc0), 64'd0);
    run_op("post_rst", 1'b0, 32'hFFFFFFFF, 32'h00000010, 64'h0000000F_0FFFFFFF, 33, 32);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
